// File: rtl/imem_pkg.sv
// Shared types and size defaults for the instruction-memory arbiter.
// Optional runtime loading is enabled by IMEM_ARB_RUNTIME_LOAD_EN.
package imem_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int IMEM_ADDR_SIZE    = 10;
    localparam int IMEM_WORD_SIZE    = 32;
    localparam int IMEM_STARVE_LIMIT = 8;

    function automatic int ctr_width(input int limit);
        return $clog2(limit + 1);
    endfunction

    localparam int IMEM_CTR_W = ctr_width(IMEM_STARVE_LIMIT);

endpackage

// File: rtl/imem_arbiter_starve_ctr.sv
// Saturating count of consecutive fetch wins over a pending loader write.
// Used only when IMEM_ARB_RUNTIME_LOAD_EN is defined.
module starve_ctr
    import imem_pkg::*;
#(
    parameter int LIMIT = IMEM_STARVE_LIMIT,
    parameter int W     = ctr_width(LIMIT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    input  logic i_valid,
    output logic o_force
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != LIM)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_force = i_valid && (r_count == LIM);

endmodule

// File: rtl/imem_arbiter.sv
// Instruction RAM arbiter between fetch and the boot/runtime loader.
// Define IMEM_ARB_RUNTIME_LOAD_EN to allow loader writes while running.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_SIZE    = IMEM_ADDR_SIZE,
    parameter int WORD_SIZE    = IMEM_WORD_SIZE,
    parameter int STARVE_LIMIT = IMEM_STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_req,
    input  logic [WORD_SIZE-1:0] fetch_addr,
    output logic                 fetch_gnt,
    output logic                 fetch_valid,
    output logic [WORD_SIZE-1:0] fetch_data,
    input  logic                 load_valid,
    input  logic [WORD_SIZE-1:0] load_addr,
    input  logic [WORD_SIZE-1:0] load_data,
    output logic                 load_ready,
    input  logic                 load_done,
    output logic                 cpu_hold,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    state_t r_state;
    logic   r_fetch_valid;

    logic w_boot;
    logic w_fetch_gnt;
    logic w_load_ready;
    logic w_load_acc;
    logic w_unused;

    assign w_boot     = (r_state == ST_BOOT);
    assign w_load_acc = load_valid && w_load_ready;

`ifdef IMEM_ARB_RUNTIME_LOAD_EN
    logic w_force;

    assign w_fetch_gnt  = !w_boot && fetch_req && !w_force;
    assign w_load_ready = w_boot || !w_fetch_gnt;

    starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .W     (ctr_width(STARVE_LIMIT))
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (load_valid && w_fetch_gnt),
        .i_clr   (!load_valid || w_load_acc),
        .i_valid (load_valid),
        .o_force (w_force)
    );
`else
    assign w_fetch_gnt  = !w_boot && fetch_req;
    assign w_load_ready = w_boot;
`endif

    // Upper word-index bits are deliberately dropped.
    assign w_unused = ^{fetch_addr[WORD_SIZE-1:ADDR_SIZE],
                        load_addr[WORD_SIZE-1:ADDR_SIZE]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_BOOT;
            r_fetch_valid <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch_gnt;
            unique case (r_state)
                ST_BOOT: if (load_done) r_state <= ST_RUN;
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = fetch_addr[ADDR_SIZE-1:0];
        mem_wdata = load_data;
        unique case (1'b1)
            w_fetch_gnt: begin
                mem_en = 1'b1;
            end
            w_load_acc: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = load_addr[ADDR_SIZE-1:0];
            end
            default: ;
        endcase
    end

    assign fetch_gnt   = w_fetch_gnt;
    assign fetch_valid = r_fetch_valid;
    assign fetch_data  = mem_rdata;
    assign load_ready  = w_load_ready;
    assign cpu_hold    = w_boot;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a behavioural RAM.
// Runtime-load checks follow IMEM_ARB_RUNTIME_LOAD_EN.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        load_valid;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_ready;
    logic        load_done;
    logic        cpu_hold;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    imem_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .load_valid  (load_valid),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .cpu_hold    (cpu_hold),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        load_valid = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        load_done  = 1'b0;
        #3;
        chk("rst_hold",  32'(cpu_hold),    32'd1);
        chk("rst_lrdy",  32'(load_ready),  32'd1);
        chk("rst_gnt",   32'(fetch_gnt),   32'd0);
        chk("rst_men",   32'(mem_en),      32'd0);
        chk("rst_fval",  32'(fetch_valid), 32'd0);
        nxt();
        nxt();
        rst_n = 1'b1;

        nxt();
        fetch_req  = 1'b1;
        fetch_addr = 32'd3;
        load_valid = 1'b1;
        load_addr  = 32'd3;
        load_data  = 32'hDEAD_BEEF;
        settle();
        chk("boot_gnt",  32'(fetch_gnt),  32'd0);
        chk("boot_hold", 32'(cpu_hold),   32'd1);
        chk("boot_lrdy", 32'(load_ready), 32'd1);
        chk("boot_we",   32'(mem_we),     32'd1);
        chk("boot_addr", 32'(mem_addr),   32'd3);

        nxt();
        load_addr = 32'd4;
        load_data = 32'h1234_5678;
        settle();
        chk("boot_addr4", 32'(mem_addr), 32'd4);
        chk("boot_wd4",   mem_wdata,     32'h1234_5678);

        nxt();
        load_addr = 32'd7;
        load_data = 32'hA5A5_A5A5;
        load_done = 1'b1;
        settle();
        chk("done_hold", 32'(cpu_hold), 32'd1);
        chk("done_we",   32'(mem_we),   32'd1);

        nxt();
        load_valid = 1'b0;
        load_done  = 1'b0;
        fetch_addr = 32'd3;
        settle();
        chk("run_hold", 32'(cpu_hold),  32'd0);
        chk("run_gnt",  32'(fetch_gnt), 32'd1);
        chk("run_we",   32'(mem_we),    32'd0);
        chk("run_addr", 32'(mem_addr),  32'd3);

        nxt();
        fetch_addr = 32'd4;
        load_done  = 1'b1;
        settle();
        chk("rd3_val", 32'(fetch_valid), 32'd1);
        chk("rd3_dat", fetch_data,       32'hDEAD_BEEF);

        nxt();
        fetch_addr = 32'hFFFF_FC07;
        load_done  = 1'b0;
        settle();
        chk("ign_done", 32'(cpu_hold), 32'd0);
        chk("rd4_dat",  fetch_data,    32'h1234_5678);
        chk("hi_addr",  32'(mem_addr), 32'd7);

        nxt();
        fetch_req = 1'b0;
        settle();
        chk("rd7_val",  32'(fetch_valid), 32'd1);
        chk("rd7_dat",  fetch_data,       32'hA5A5_A5A5);
        chk("idle_men", 32'(mem_en),      32'd0);

        nxt();
        settle();
        chk("idle_fval", 32'(fetch_valid), 32'd0);

`ifdef IMEM_ARB_RUNTIME_LOAD_EN
        load_valid = 1'b1;
        load_addr  = 32'd9;
        load_data  = 32'hCAFE_F00D;
        settle();
        chk("iw_lrdy", 32'(load_ready), 32'd1);
        chk("iw_we",   32'(mem_we),     32'd1);
        chk("iw_gnt",  32'(fetch_gnt),  32'd0);

        for (int i = 0; i < 20; i++) begin
            nxt();
            fetch_req  = 1'b1;
            fetch_addr = 32'd9;
            load_addr  = 32'd10;
            load_data  = 32'h0BAD_C0DE;
            settle();
            chk($sformatf("stv_gnt%0d", i),
                32'(fetch_gnt), 32'((i % 9) != 8));
            chk($sformatf("stv_rdy%0d", i),
                32'(load_ready), 32'((i % 9) == 8));
        end

        nxt();
        load_valid = 1'b0;
        fetch_addr = 32'd10;
        settle();
        chk("fw_gnt", 32'(fetch_gnt), 32'd1);
        nxt();
        fetch_addr = 32'd9;
        settle();
        chk("fw_dat", fetch_data, 32'h0BAD_C0DE);
        nxt();
        settle();
        chk("iw_dat", fetch_data, 32'hCAFE_F00D);
`else
        load_valid = 1'b1;
        load_addr  = 32'd11;
        load_data  = 32'h5555_AAAA;
        for (int i = 0; i < 20; i++) begin
            nxt();
            fetch_req  = ((i % 3) != 0);
            fetch_addr = 32'd3;
            settle();
            chk($sformatf("off_rdy%0d", i),
                32'(load_ready), 32'd0);
            chk($sformatf("off_gnt%0d", i),
                32'(fetch_gnt), 32'((i % 3) != 0));
            chk($sformatf("off_we%0d", i),
                32'(mem_we), 32'd0);
        end
        load_valid = 1'b0;
`endif

        nxt();
        fetch_req  = 1'b1;
        fetch_addr = 32'd3;
        settle();
        chk("mr_gnt", 32'(fetch_gnt), 32'd1);
        nxt();
        rst_n = 1'b0;
        settle();
        chk("mr_fval", 32'(fetch_valid), 32'd0);
        chk("mr_hold", 32'(cpu_hold),    32'd1);
        chk("mr_lrdy", 32'(load_ready),  32'd1);
        chk("mr_gnt0", 32'(fetch_gnt),   32'd0);
        nxt();
        rst_n = 1'b1;
        settle();
        chk("mr_boot", 32'(cpu_hold), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-port instruction memory between the fetch stage and the program loader, and sequences the core's boot. After reset, the loader owns the memory and the core is held. Once the loader signals completion, fetch owns the memory. Optionally, the loader may continue to write at runtime under a starvation-bounded priority scheme. Sits between the fetch stage, the loader and the instruction RAM.

## Interface
- `ADDR_SIZE`, 10, word-address width of instruction RAM
- `WORD_SIZE`, 32, instruction/data width
- `STARVE_LIMIT`, 8, consecutive fetch wins before a pending loader write is forced through (≥1)

Ports:
- `clk` in 1: single clock; all logic rising-edge
- `rst_n` in 1: asynchronous, active-low reset
- `fetch_req` in 1: fetch wants a word this cycle
- `fetch_addr` in WORD_SIZE: word index; only [ADDR_SIZE-1:0] used
- `fetch_gnt` out 1: fetch access issued this cycle; low means stall the PC
- `fetch_valid` out 1: `fetch_data` holds the word for the access granted one cycle earlier
- `fetch_data` out WORD_SIZE: read data
- `load_valid` in 1: loader write pending
- `load_addr` in WORD_SIZE: word index; only [ADDR_SIZE-1:0] used
- `load_data` in WORD_SIZE: write data
- `load_ready` out 1: write accepted this cycle when `load_valid` & `load_ready`
- `load_done` in 1: pulse; end of boot load
- `cpu_hold` out 1: hold core in reset/stall while booting
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out ADDR_SIZE, `mem_wdata` out WORD_SIZE: RAM port
- `mem_rdata` in WORD_SIZE: synchronous read data, 1-cycle latency

## Operation
- **States:** BOOT, RUN. Reset enters BOOT.
- **BOOT:**
  - `load_ready`=1, `fetch_gnt`=0, `cpu_hold`=1.
  - Accepted writes drive `mem_en`=`mem_we`=1.
  - `load_done` → RUN at the next edge. A write presented in the same cycle as `load_done` is still performed.
- **RUN:**
  - `cpu_hold`=0. `load_done` is ignored.
  - Fetch has priority: `fetch_gnt` = `fetch_req` & !force.
  - Grant drives `mem_en`=1, `mem_we`=0, `mem_addr`=`fetch_addr`[ADDR_SIZE-1:0].
- **Starvation counter:**
  - Increments each cycle in which `load_valid` & `fetch_gnt`.
  - Clears on any loader acceptance or when `load_valid`=0.
  - force = (count == STARVE_LIMIT) & `load_valid`. In a force cycle, the loader is granted and `fetch_gnt`=0.
- **Memory mux:** `mem_*` are combinational from state and grants. With no grant, `mem_en`=0.
- **Read return:** `fetch_valid` is registered as `fetch_gnt` delayed one cycle. `fetch_data` = `mem_rdata` (pass-through).
- **Address width:** upper address bits are ignored; no range error.

## Timing
- **Reset values:** state=BOOT, `fetch_valid`=0, counter=0. Combinational outputs at reset: `cpu_hold`=1, `load_ready`=1, `fetch_gnt`=0, `mem_en`=0.
- **Read latency:** request cycle N with grant → data and `fetch_valid` in cycle N+1.
- **BOOT→RUN:** `cpu_hold` falls at the edge after `load_done`. The first fetch can be granted in that same cycle.
- **Reset mid-operation:** asserting `rst_n` low immediately forces BOOT and clears `fetch_valid` and the counter. An in-flight read is discarded.
- **Stall behaviour:** a fetch stalled by force sees `fetch_gnt`=0 for exactly one cycle per forced write.

## Configuration
- `IMEM_ARB_RUNTIME_LOAD_EN`:
  - **Defined:** runtime loader writes and starvation forcing in RUN, as above.
  - **Undefined:** in RUN, `load_ready`=0 always, no counter is instantiated, and `fetch_gnt`=`fetch_req`. BOOT behaviour is unchanged.

## Structure
- `imem_pkg`:
  - state typedef (BOOT, RUN)
  - counter width constant = $clog2(STARVE_LIMIT+1)
  - shared ADDR/WORD size defaults
- One sub-module: `starve_ctr` (saturating consecutive-win counter with clear and force output). It is instantiated only under `IMEM_ARB_RUNTIME_LOAD_EN`.

## Test plan
- **Boot load:** reset, write 0xDEADBEEF@3 and 0x12345678@4 in BOOT, pulse `load_done`. Required: `cpu_hold`=1 until the edge after `load_done`; fetch addr 3 then 4 returns those words with `fetch_valid` one cycle after each grant.
- **Write coincident with done:** `load_done` coincident with a write of 0xA5A5A5A5@7. Required: the write lands; a subsequent fetch@7 returns 0xA5A5A5A5.
- **Starvation (macro on, STARVE_LIMIT=8):** `fetch_req` continuously high, `load_valid` held high from cycle 0. Required: `fetch_gnt`=0 for exactly one cycle after 8 fetch wins; `load_ready`=1 in that cycle; the counter then restarts.
- **Idle-cycle write (macro on):** `fetch_req`=0 with `load_valid`=1. Required: immediate acceptance and no counter increment.
- **Macro off:** in RUN, `load_valid`=1 for 20 cycles. Required: `load_ready`=0 throughout and `fetch_gnt` follows `fetch_req`.
- **Reset mid-operation:** `rst_n` low in the cycle after a fetch grant. Required: `fetch_valid`=0 immediately, `cpu_hold`=1, and state BOOT.
